// File: rtl/lbp_table_sched.sv
// Single-port scheduler for the local branch predictor pattern table.
// Arbitrates frontend lookups, RMW counter updates and the clearing sweep.
module lbp_table_sched #(
    parameter int NR_ENTRIES = 1024,
    parameter int IDX_W      = $clog2(NR_ENTRIES),
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             lookup_valid_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             lookup_ready_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [IDX_W-1:0] mem_addr_o,
    output logic [1:0]       mem_wdata_o,
    input  logic [1:0]       mem_rdata_i,
    output logic             busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {SWEEP, IDLE, UPD_RD, UPD_WR} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       sweep_idx_q;
    logic [IDX_W-1:0]       fifo_idx_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_taken_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [ST_W-1:0]        starve_q;
    logic [1:0]             cnt_q;
    logic                   first_q;

    logic             full;
    logic             empty;
    logic             force_wr;
    logic             lookup_gnt;
    logic             sweep_act;
    logic             upd_rd;
    logic             upd_wr;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic [1:0]       old_cnt;
    logic [1:0]       new_cnt;

    assign full       = count_q == CNT_W'(FIFO_DEPTH);
    assign empty      = count_q == '0;
    assign head_idx   = fifo_idx_q[rd_ptr_q];
    assign head_taken = fifo_taken_q[rd_ptr_q];

    assign force_wr   = state_q == UPD_WR && starve_q == ST_W'(STARVE_MAX);
    assign lookup_gnt = !rst_i && lookup_valid_i
                        && state_q != SWEEP && !force_wr;
    assign sweep_act  = !rst_i && state_q == SWEEP;
    assign upd_rd     = !rst_i && !flush_i
                        && state_q == UPD_RD && !lookup_gnt;
    assign upd_wr     = !rst_i && !flush_i && state_q == UPD_WR
                        && (force_wr || !lookup_gnt);
    assign pop        = upd_wr;

    // A full queue may still accept when its head retires this cycle.
    assign upd_ready_o = !rst_i && !flush_i && state_q != SWEEP
                         && (!full || pop);
    assign push        = upd_valid_i && upd_ready_o;

    assign lookup_ready_o = lookup_gnt;
    assign busy_o         = rst_i || state_q == SWEEP;

    assign old_cnt = first_q ? mem_rdata_i : cnt_q;

    always_comb begin
        new_cnt = old_cnt;
        if (head_taken) begin
            if (old_cnt != 2'd3) new_cnt = old_cnt + 2'd1;
        end else begin
            if (old_cnt != 2'd0) new_cnt = old_cnt - 2'd1;
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 2'b00;
        unique case (1'b1)
            sweep_act: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = sweep_idx_q;
                mem_wdata_o = 2'b01;
            end
            lookup_gnt: begin
                mem_req_o  = 1'b1;
                mem_addr_o = lookup_idx_i;
            end
            upd_rd: begin
                mem_req_o  = 1'b1;
                mem_addr_o = head_idx;
            end
            upd_wr: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = head_idx;
                mem_wdata_o = new_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q]   <= upd_idx_i;
            fifo_taken_q[wr_ptr_q] <= upd_taken_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q     <= SWEEP;
            sweep_idx_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            cnt_q       <= 2'b00;
            first_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            unique case (state_q)
                SWEEP: begin
                    sweep_idx_q <= sweep_idx_q + IDX_W'(1);
                    if (sweep_idx_q == IDX_W'(NR_ENTRIES - 1))
                        state_q <= IDLE;
                end
                IDLE: begin
                    if (!empty) state_q <= UPD_RD;
                end
                UPD_RD: begin
                    if (upd_rd) begin
                        state_q <= UPD_WR;
                        first_q <= 1'b1;
                    end
                end
                UPD_WR: begin
                    if (first_q) cnt_q <= mem_rdata_i;
                    first_q <= 1'b0;
                    if (upd_wr) begin
                        starve_q <= '0;
                        if (count_q > CNT_W'(1) || push)
                            state_q <= UPD_RD;
                        else
                            state_q <= IDLE;
                    end else begin
                        starve_q <= starve_q + ST_W'(1);
                    end
                end
                default: state_q <= SWEEP;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_table_sched.sv
// Directed bench for lbp_table_sched with a behavioural pattern-table SRAM.
// Checks sweep, RMW updates, lookup priority, starvation, FIFO full, flush, reset.
module tb_lbp_table_sched;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic       lookup_valid_i;
    logic [9:0] lookup_idx_i;
    logic       lookup_ready_o;
    logic       upd_valid_i;
    logic [9:0] upd_idx_i;
    logic       upd_taken_i;
    logic       upd_ready_o;
    logic       mem_req_o;
    logic       mem_we_o;
    logic [9:0] mem_addr_o;
    logic [1:0] mem_wdata_o;
    logic [1:0] mem_rdata_i = 2'b00;
    logic       busy_o;

    logic [1:0] sram [1024];

    int n_cmp = 0;
    int n_bad = 0;

    lbp_table_sched dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_idx_i   (lookup_idx_i),
        .lookup_ready_o (lookup_ready_o),
        .upd_valid_i    (upd_valid_i),
        .upd_idx_i      (upd_idx_i),
        .upd_taken_i    (upd_taken_i),
        .upd_ready_o    (upd_ready_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i <= sram[mem_addr_o];
        end
    end

    // {busy, lookup_ready, upd_ready, req, we, addr, wdata}
    function automatic logic [31:0] mk(bit busy, bit lr, bit ur, bit req,
                                       bit we, int addr, int wd);
        logic [9:0] a;
        logic [1:0] w;
        a = addr[9:0];
        w = wd[1:0];
        return {15'b0, busy, lr, ur, req, we, a, w};
    endfunction

    function automatic logic [31:0] obs();
        return {15'b0, busy_o, lookup_ready_o, upd_ready_o,
                mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(string tag, logic [31:0] exp);
        #2;
        check(tag, obs(), exp);
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        upd_valid_i = 0; lookup_valid_i = 0; flush_i = 0; rst_i = 0;
    endtask

    task automatic sweep_chk(string tag, int n);
        for (int i = 0; i < n; i++) cyc(tag, mk(1, 0, 0, 1, 1, i, 1));
    endtask

    task automatic upd_once(int idx, bit tk, int exp_w);
        upd_valid_i = 1; upd_idx_i = idx[9:0]; upd_taken_i = tk;
        cyc("upd_enq", mk(0, 0, 1, 0, 0, 0, 0));
        upd_valid_i = 0;
        cyc("upd_idle", mk(0, 0, 1, 0, 0, 0, 0));
        cyc("upd_rd", mk(0, 0, 1, 1, 0, idx, 0));
        cyc("upd_wr", mk(0, 0, 1, 1, 1, idx, exp_w));
    endtask

    initial begin
        rst_i = 1; flush_i = 0;
        upd_valid_i = 0; upd_idx_i = 0; upd_taken_i = 0;
        lookup_valid_i = 1; lookup_idx_i = 10'd9;
        @(posedge clk_i);
        #1;
        cyc("rst0", mk(1, 0, 0, 0, 0, 0, 0));
        cyc("rst1", mk(1, 0, 0, 0, 0, 0, 0));

        // 1: post-reset sweep with a lookup held pending
        rst_i = 0;
        sweep_chk("sweep_init", 1024);
        cyc("sweep_done", mk(0, 1, 1, 1, 0, 9, 0));
        quiet();
        cyc("idle", mk(0, 0, 1, 0, 0, 0, 0));

        // 2: saturating counter at idx 5
        upd_once(5, 1, 2);
        upd_once(5, 1, 3);
        upd_once(5, 1, 3);
        upd_once(5, 0, 2);
        upd_once(5, 0, 1);
        upd_once(5, 0, 0);
        upd_once(5, 0, 0);

        // 3: starvation forces the write after three lost cycles
        upd_valid_i = 1; upd_idx_i = 10'd7; upd_taken_i = 1;
        cyc("st_enq", mk(0, 0, 1, 0, 0, 0, 0));
        upd_valid_i = 0;
        cyc("st_idle", mk(0, 0, 1, 0, 0, 0, 0));
        cyc("st_rd", mk(0, 0, 1, 1, 0, 7, 0));
        lookup_valid_i = 1; lookup_idx_i = 10'd3;
        cyc("st_lk1", mk(0, 1, 1, 1, 0, 3, 0));
        cyc("st_lk2", mk(0, 1, 1, 1, 0, 3, 0));
        cyc("st_lk3", mk(0, 1, 1, 1, 0, 3, 0));
        cyc("st_force", mk(0, 0, 1, 1, 1, 7, 2));
        cyc("st_after", mk(0, 1, 1, 1, 0, 3, 0));
        quiet();
        cyc("st_quiet", mk(0, 0, 1, 0, 0, 0, 0));

        // 4: fill the queue behind continuous lookups
        lookup_valid_i = 1; lookup_idx_i = 10'd0;
        upd_valid_i = 1; upd_taken_i = 1;
        for (int i = 0; i < 4; i++) begin
            upd_idx_i = 10'(10 + i);
            cyc("ff_enq", mk(0, 1, 1, 1, 0, 0, 0));
        end
        upd_idx_i = 10'd14;
        cyc("ff_full", mk(0, 1, 0, 1, 0, 0, 0));
        quiet();
        cyc("ff_rd10", mk(0, 0, 0, 1, 0, 10, 0));
        cyc("ff_wr10", mk(0, 0, 1, 1, 1, 10, 2));
        cyc("ff_rd11", mk(0, 0, 1, 1, 0, 11, 0));
        cyc("ff_wr11", mk(0, 0, 1, 1, 1, 11, 2));
        cyc("ff_rd12", mk(0, 0, 1, 1, 0, 12, 0));
        cyc("ff_wr12", mk(0, 0, 1, 1, 1, 12, 2));
        cyc("ff_rd13", mk(0, 0, 1, 1, 0, 13, 0));
        cyc("ff_wr13", mk(0, 0, 1, 1, 1, 13, 2));
        cyc("ff_empty", mk(0, 0, 1, 0, 0, 0, 0));

        // 5: flush mid-RMW, then flush mid-sweep
        upd_valid_i = 1; upd_taken_i = 1; upd_idx_i = 10'd20;
        cyc("fl_enq20", mk(0, 0, 1, 0, 0, 0, 0));
        upd_idx_i = 10'd21;
        cyc("fl_enq21", mk(0, 0, 1, 0, 0, 0, 0));
        upd_valid_i = 0;
        cyc("fl_rd20", mk(0, 0, 1, 1, 0, 20, 0));
        flush_i = 1; upd_valid_i = 1; upd_idx_i = 10'd30;
        cyc("fl_abort", mk(0, 0, 0, 0, 0, 0, 0));
        quiet();
        sweep_chk("sweep_flush", 1024);
        cyc("fl_idle0", mk(0, 0, 1, 0, 0, 0, 0));
        cyc("fl_idle1", mk(0, 0, 1, 0, 0, 0, 0));
        flush_i = 1;
        cyc("fl_idle_flush", mk(0, 0, 0, 0, 0, 0, 0));
        flush_i = 0;
        sweep_chk("sweep_part", 500);
        flush_i = 1;
        @(posedge clk_i);
        #1;
        flush_i = 0;

        // 6: reset lands at sweep index 200
        sweep_chk("sweep_restart", 200);
        rst_i = 1; lookup_valid_i = 1; upd_valid_i = 1;
        cyc("rst_mid", mk(1, 0, 0, 0, 0, 0, 0));
        quiet();
        sweep_chk("sweep_rst", 1024);
        cyc("final_idle", mk(0, 0, 1, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lbp_table_sched.md
Name: lbp_table_sched

Overview:
- Single-port access scheduler for the local branch predictor's 2-bit pattern table SRAM.
- Shares the port between three sources:
  - frontend lookups (highest priority);
  - resolved-branch updates, done as read-modify-write (RMW) saturating-counter updates;
  - a table-clearing sweep, run after reset and on flush.
- Sits between the frontend/backend predictor interfaces and the pattern table macro.

Parameters:
NR_ENTRIES, 1024, pattern table entries (power of two)
IDX_W, $clog2(NR_ENTRIES), index width
FIFO_DEPTH, 4, pending-update queue depth (power of two)
STARVE_MAX, 3, consecutive cycles a pending write may lose to lookups before it is forced

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  start a sweep; discard pending updates
lookup_valid_i  in  1  frontend read request
lookup_idx_i  in  IDX_W  lookup index
lookup_ready_o  out  1  lookup accepted this cycle
upd_valid_i  in  1  resolved-branch update request
upd_idx_i  in  IDX_W  update index
upd_taken_i  in  1  branch outcome
upd_ready_o  out  1  update queue can accept
mem_req_o  out  1  SRAM access this cycle
mem_we_o  out  1  1 = write
mem_addr_o  out  IDX_W  SRAM address
mem_wdata_o  out  2  SRAM write data
mem_rdata_i  in  2  SRAM read data, valid the cycle after a read
busy_o  out  1  sweep in progress

Behaviour:
- Reset, synchronous: state=SWEEP, sweep_idx=0, FIFO empty, starve count=0.
  - Outputs during reset: lookup_ready_o=0, upd_ready_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=1.
- Port carries at most one access per cycle; mem_* outputs are combinational from state and inputs.
- Lookup grant: lookup_ready_o = lookup_valid_i && state!=SWEEP && !force_wr.
  - On grant: mem_req_o=1, mem_we_o=0, mem_addr_o=lookup_idx_i.
- FIFO:
  - Enqueue on upd_valid_i && upd_ready_o.
  - upd_ready_o = !full && state!=SWEEP.
  - Dequeue when the entry's write completes.
  - Simultaneous enqueue and dequeue allowed when full.
- FSM:
  - SWEEP:
    - Each cycle: mem_req_o=1, mem_we_o=1, mem_addr_o=sweep_idx, mem_wdata_o=2'b01 (weakly not-taken); sweep_idx++.
    - At sweep_idx==NR_ENTRIES-1 the write completes, then go IDLE.
    - Takes exactly NR_ENTRIES cycles; busy_o=1 throughout.
  - IDLE: if FIFO non-empty, go UPD_RD.
  - UPD_RD:
    - Issue read of head index when no lookup is granted, then go UPD_WR.
    - Otherwise stay.
  - UPD_WR:
    - First cycle: latch mem_rdata_i into cnt_q. Write value is derived from mem_rdata_i in the first cycle, from cnt_q afterwards.
    - Write issued when no lookup is granted, or when force_wr.
    - new = taken ? min(cnt+1,3) : max(cnt-1,0).
    - After the write: pop FIFO, go UPD_RD if more entries remain, else IDLE.
  - force_wr = (state==UPD_WR && starve==STARVE_MAX).
    - starve increments each UPD_WR cycle lost to a lookup.
    - starve clears on a write.
- Hazards:
  - A lookup to an index mid-RMW returns the pre-update value. This is acceptable; no forwarding.
  - Updates are serialized, so no RMW overlap.
- Flush:
  - flush_i in any state: next state SWEEP, sweep_idx=0, FIFO cleared, in-flight RMW aborted with no write, starve=0.
  - flush_i during SWEEP restarts it at index 0.
  - An update presented in the flush cycle is dropped.
- rst_i mid-operation: identical to reset; pending updates lost.

Test Plan:
1. Reset, then idle:
   - Expect 1024 consecutive writes, addr 0..1023, wdata 2'b01, busy_o=1.
   - busy_o falls in cycle 1025; lookup_ready_o is 0 until then.
2. Single update to idx 5:
   - upd_idx_i=5, taken=1, no lookups.
   - Expect read addr 5, then write addr 5 with data 2'b10.
   - Two more taken updates to idx 5 give 2'b11, then stay 2'b11 (saturation).
   - Four not-taken updates give 2'b00 floor.
3. Lookup priority and starvation:
   - Update to idx 7 queued.
   - Continuous lookup_valid_i to idx 3 from UPD_WR entry.
   - Expect 3 lookups granted, then 4th cycle lookup_ready_o=0 with write to addr 7.
4. FIFO full:
   - Enqueue 4 updates while continuous lookups block the port.
   - Expect upd_ready_o=0 on the 5th.
   - After the first write completes, upd_ready_o=1; accepting in the same cycle as the pop is allowed.
5. Flush mid-RMW:
   - 2 updates queued; assert flush_i in UPD_WR.
   - Expect no write to the head index, FIFO empty, and a full 1024-cycle sweep from addr 0.
   - flush_i again at sweep_idx=500 restarts at 0.
6. Reset mid-sweep:
   - rst_i at sweep_idx=200 restarts the sweep at 0, with all outputs at their reset values during the reset cycle.
